// File: rtl/dmem_block_mover_if.sv
// Memory-side port of the block mover: single-word read/write requests,
// returned read data and the memory's completion strobe.
interface dmem_block_mover_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 48
);
    logic [ADDR_W-1:0] addr;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              mdone;

    // Engine side: issues requests, consumes data and completion.
    modport master (
        output addr,
        output read,
        output write,
        output wdata,
        input  rdata,
        input  mdone
    );

    // Memory side: serves requests and signals completion.
    modport slave (
        input  addr,
        input  read,
        input  write,
        input  wdata,
        output rdata,
        output mdone
    );
endinterface

// File: rtl/dmem_block_mover.sv
// Block copy/fill engine for the data memory port. Moves one word at a time
// using single-cycle read/write requests and waits on the memory's done
// strobe between them. Owns the memory port whenever busy.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a start; address/data outputs hold last values
// RD    | one-cycle read request at the current source address
// RWAIT | waiting for read completion; captures the returned word
// WR    | one-cycle write request at the current destination address
// WWAIT | waiting for write completion; advances pointers, decides exit
module dmem_block_mover #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 48
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic              i_fill,
    input  logic [ADDR_W-1:0] i_src,
    input  logic [ADDR_W-1:0] i_dst,
    input  logic [ADDR_W-1:0] i_count,
    input  logic [DATA_W-1:0] i_pattern,
    input  logic              i_abort,
    dmem_block_mover_if.master mem,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_aborted,
    output logic [ADDR_W-1:0] o_remaining
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        RWAIT = 3'd2,
        WR    = 3'd3,
        WWAIT = 3'd4
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W-1:0] rem_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] pattern_q;
    logic [DATA_W-1:0] wdata_q;
    logic              fill_q;
    logic              abort_q;
    logic              done_q;
    logic              aborted_q;

    logic              read_c;
    logic              write_c;
    logic              busy_c;
    logic              abort_now;
    logic              last_word;
    logic              word_done;
    logic              exit_now;
    logic [ADDR_W-1:0] src_inc;
    logic [ADDR_W-1:0] dst_inc;

    // An abort raised in the very cycle the write completes still counts;
    // the pointer increments wrap naturally at the top of the address space.
    assign abort_now = abort_q | i_abort;
    assign last_word = (rem_q == ADDR_W'(1));
    assign word_done = (state_q == WWAIT) && mem.mdone;
    assign exit_now  = word_done && (last_word || abort_now);
    assign src_inc   = src_q + ADDR_W'(1);
    assign dst_inc   = dst_q + ADDR_W'(1);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection and request strobes.
    always_comb begin
        state_d = state_q;
        read_c  = 1'b0;
        write_c = 1'b0;
        busy_c  = 1'b1;
        unique case (state_q)
            IDLE: begin
                busy_c = 1'b0;
                if (i_start && (i_count != '0)) begin
                    state_d = i_fill ? WR : RD;
                end
            end
            RD: begin
                read_c  = 1'b1;
                state_d = RWAIT;
            end
            RWAIT: begin
                if (mem.mdone) begin
                    state_d = WR;
                end
            end
            WR: begin
                write_c = 1'b1;
                state_d = WWAIT;
            end
            WWAIT: begin
                if (mem.mdone) begin
                    if (last_word || abort_now) begin
                        state_d = IDLE;
                    end else begin
                        state_d = fill_q ? WR : RD;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_c  = 1'b0;
            end
        endcase
    end

    // Datapath: operand latches, address/data presented to memory, status.
    // The address for the next request is loaded on the edge that enters
    // RD or WR so it is already stable during the one-cycle request.
    always_ff @(posedge clk) begin
        if (reset) begin
            src_q     <= '0;
            dst_q     <= '0;
            rem_q     <= '0;
            addr_q    <= '0;
            pattern_q <= '0;
            wdata_q   <= '0;
            fill_q    <= 1'b0;
            abort_q   <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != IDLE && i_abort) begin
                abort_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    abort_q <= 1'b0;
                    if (i_start) begin
                        src_q     <= i_src;
                        dst_q     <= i_dst;
                        rem_q     <= i_count;
                        fill_q    <= i_fill;
                        pattern_q <= i_pattern;
                        aborted_q <= 1'b0;
                        if (i_count == '0) begin
                            done_q <= 1'b1;
                        end else if (i_fill) begin
                            addr_q  <= i_dst;
                            wdata_q <= i_pattern;
                        end else begin
                            addr_q <= i_src;
                        end
                    end
                end
                RWAIT: begin
                    if (mem.mdone) begin
                        wdata_q <= mem.rdata;
                        addr_q  <= dst_q;
                    end
                end
                WWAIT: begin
                    if (mem.mdone) begin
                        src_q <= src_inc;
                        dst_q <= dst_inc;
                        rem_q <= rem_q - ADDR_W'(1);
                        if (exit_now) begin
                            done_q    <= 1'b1;
                            aborted_q <= abort_now && !last_word;
                            abort_q   <= 1'b0;
                        end else if (fill_q) begin
                            addr_q  <= dst_inc;
                            wdata_q <= pattern_q;
                        end else begin
                            addr_q <= src_inc;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem.addr    = addr_q;
    assign mem.wdata   = wdata_q;
    assign mem.read    = read_c;
    assign mem.write   = write_c;
    assign o_busy      = busy_c;
    assign o_done      = done_q;
    assign o_aborted   = aborted_q;
    assign o_remaining = rem_q;

endmodule

// File: tb/tb_dmem_block_mover.sv
// Bench for dmem_block_mover: a latency-configurable memory model, a bus
// monitor, and a reference model that replays each operation word by word
// on a shadow memory image.
module tb_dmem_block_mover;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 48;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_start;
    logic              i_fill;
    logic [ADDR_W-1:0] i_src;
    logic [ADDR_W-1:0] i_dst;
    logic [ADDR_W-1:0] i_count;
    logic [DATA_W-1:0] i_pattern;
    logic              i_abort;
    logic              o_busy;
    logic              o_done;
    logic              o_aborted;
    logic [ADDR_W-1:0] o_remaining;

    int n_checks = 0;
    int n_errors = 0;

    dmem_block_mover_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_block_mover #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_start     (i_start),
        .i_fill      (i_fill),
        .i_src       (i_src),
        .i_dst       (i_dst),
        .i_count     (i_count),
        .i_pattern   (i_pattern),
        .i_abort     (i_abort),
        .mem         (bus),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_aborted   (o_aborted),
        .o_remaining (o_remaining)
    );

    always #5 clk = ~clk;

    // Memory model state; only the memory process writes mem.
    logic [DATA_W-1:0] mem     [DEPTH];
    logic [DATA_W-1:0] ref_mem [DEPTH];
    bit                mem_inited = 1'b0;
    int                lat = 1;
    int                lat_cnt = 0;
    logic              pl_en = 1'b0;
    logic [ADDR_W-1:0] pl_addr = '0;
    logic [DATA_W-1:0] pl_data = '0;

    function automatic logic [DATA_W-1:0] init_word(input int a);
        logic [31:0] h;
        logic [31:0] av;
        av = a;
        h  = (av * 32'h9E3779B1) ^ 32'h5BD1E995;
        return {av[15:0] ^ 16'hC3A5, h};
    endfunction

    // Memory: captures a request on the edge it is seen, raises mdone for
    // one cycle lat cycles later; address 0 always reads as zero.
    always @(posedge clk) begin
        if (!mem_inited) begin
            for (int a = 0; a < DEPTH; a++) mem[a] = init_word(a);
            mem_inited = 1'b1;
        end
        if (pl_en) mem[pl_addr] = pl_data;
        if (bus.read || bus.write) begin
            if (bus.write) mem[bus.addr] = bus.wdata;
            else bus.rdata <= (bus.addr == '0) ? '0 : mem[bus.addr];
            if (lat <= 1) begin
                bus.mdone <= 1'b1;
                lat_cnt   <= 0;
            end else begin
                bus.mdone <= 1'b0;
                lat_cnt   <= lat - 1;
            end
        end else if (lat_cnt != 0) begin
            lat_cnt   <= lat_cnt - 1;
            bus.mdone <= (lat_cnt == 1);
        end else begin
            bus.mdone <= 1'b0;
        end
    end

    // Bus monitor: request counts, busy cycles, done pulses, ordering errors.
    logic mon_clr  = 1'b0;
    logic mon_copy = 1'b0;
    int   rd_cnt, wr_cnt, busy_cnt, done_cnt, alt_err, last_kind;

    always @(posedge clk) begin
        int inc;
        if (mon_clr) begin
            rd_cnt <= 0; wr_cnt <= 0; busy_cnt <= 0; done_cnt <= 0;
            alt_err <= 0; last_kind <= 0;
        end else begin
            inc = 0;
            if (bus.read && bus.write) inc++;
            if (bus.read) begin
                if (last_kind == 1) inc++;
                last_kind <= 1;
                rd_cnt    <= rd_cnt + 1;
            end
            if (bus.write) begin
                if (mon_copy && last_kind != 1) inc++;
                last_kind <= 2;
                wr_cnt    <= wr_cnt + 1;
            end
            if (o_busy) busy_cnt <= busy_cnt + 1;
            if (o_done) done_cnt <= done_cnt + 1;
            alt_err <= alt_err + inc;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: the block move as a plain ascending word loop.
    task automatic ref_apply(input bit fill, input int src, input int dst, input int n,
                             input logic [DATA_W-1:0] pat);
        for (int i = 0; i < n; i++) begin
            int s, d;
            s = (src + i) % DEPTH;
            d = (dst + i) % DEPTH;
            ref_mem[d] = fill ? pat : ((s == 0) ? '0 : ref_mem[s]);
        end
    endtask

    task automatic check_mem(input string tag);
        int d = 0;
        for (int a = 0; a < DEPTH; a++) if (mem[a] !== ref_mem[a]) d++;
        check_val({tag, "/mem"}, d, 0);
    endtask

    task automatic preload(input int a, input logic [DATA_W-1:0] v);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = ADDR_W'(a); pl_data = v;
        @(negedge clk);
        pl_en = 1'b0;
        ref_mem[a] = v;
    endtask

    task automatic run_op(input string name, input bit fill, input int src, input int dst,
                          input int cnt, input logic [DATA_W-1:0] pat, input int abort_at,
                          input int lat_i);
        int p, k, exp_t, t;
        bit found;
        p     = fill ? (1 + lat_i) : (2 + 2 * lat_i);
        k     = (abort_at < 0) ? cnt : (abort_at / p + 1);
        if (k > cnt) k = cnt;
        exp_t = k * p;
        @(negedge clk);
        lat = lat_i; mon_copy = !fill; mon_clr = 1'b1;
        @(negedge clk);
        mon_clr = 1'b0;
        i_start = 1'b1; i_fill = fill; i_src = ADDR_W'(src); i_dst = ADDR_W'(dst);
        i_count = ADDR_W'(cnt); i_pattern = pat;
        @(posedge clk);
        t = 0; found = 1'b0;
        while (!found && t < 2000) begin
            @(negedge clk);
            i_start = 1'b0;
            i_abort = (t == abort_at);
            if (t == 0 && cnt != 0) check_val({name, "/rem_start"}, o_remaining, cnt);
            if (o_done) found = 1'b1;
            else t++;
        end
        i_abort = 1'b0;
        check_val({name, "/done_seen"}, found, 1);
        check_val({name, "/done_cycle"}, t, exp_t);
        check_val({name, "/remaining"}, o_remaining, cnt - k);
        check_val({name, "/aborted"}, o_aborted, (k < cnt));
        @(negedge clk);
        check_val({name, "/done_width"}, o_done, 0);
        @(negedge clk);
        check_val({name, "/done_cnt"}, done_cnt, 1);
        check_val({name, "/reads"}, rd_cnt, fill ? 0 : k);
        check_val({name, "/writes"}, wr_cnt, k);
        check_val({name, "/order"}, alt_err, 0);
        check_val({name, "/busy_cycles"}, busy_cnt, exp_t);
        ref_apply(fill, src, dst, k, pat);
        check_mem(name);
    endtask

    initial begin
        reset = 1'b1; i_start = 1'b0; i_fill = 1'b0; i_src = '0; i_dst = '0;
        i_count = '0; i_pattern = '0; i_abort = 1'b0;
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = init_word(a);
        repeat (3) @(negedge clk);
        check_val("rst/busy", o_busy, 0);
        check_val("rst/done", o_done, 0);
        check_val("rst/aborted", o_aborted, 0);
        check_val("rst/remaining", o_remaining, 0);
        check_val("rst/addr", bus.addr, 0);
        check_val("rst/wdata", bus.wdata, 0);
        check_val("rst/rdwr", {bus.read, bus.write}, 0);
        reset = 1'b0;
        @(negedge clk);

        preload(100, 48'hAAAA_0000_0001);
        preload(101, 48'hBBBB_0000_0002);
        preload(102, 48'hCCCC_0000_0003);
        preload(103, 48'hDDDD_0000_0004);
        run_op("copy4", 1'b0, 100, 200, 4, '0, -1, 1);
        run_op("fill_wrap", 1'b1, 16'h7FFE, 16'h7FFE, 3, 48'h1234_5678_9ABC, -1, 1);
        run_op("zero_cnt", 1'b0, 50, 60, 0, '0, -1, 1);
        run_op("abort_w3", 1'b0, 1000, 2000, 10, '0, 8, 1);

        // Reset during the second word's read wait with a slow memory.
        begin
            @(negedge clk);
            lat = 3;
            @(negedge clk);
            i_start = 1'b1; i_fill = 1'b0; i_src = ADDR_W'(300); i_dst = ADDR_W'(400);
            i_count = ADDR_W'(5);
            @(posedge clk);
            @(negedge clk);
            i_start = 1'b0;
            repeat (9) @(negedge clk);
            check_val("rst_mid/busy_before", o_busy, 1);
            reset = 1'b1;
            @(negedge clk);
            check_val("rst_mid/busy", o_busy, 0);
            check_val("rst_mid/outs", {o_done, o_aborted, bus.read, bus.write}, 0);
            check_val("rst_mid/remaining", o_remaining, 0);
            check_val("rst_mid/addr", bus.addr, 0);
            check_val("rst_mid/wdata", bus.wdata, 0);
            reset = 1'b0;
            repeat (6) @(negedge clk);
            check_val("rst_mid/idle_after", {o_busy, o_done}, 0);
            ref_apply(1'b0, 300, 400, 1, '0);
            check_mem("rst_mid");
        end
        run_op("after_rst", 1'b0, 300, 400, 5, '0, -1, 3);

        preload(10, 48'hFEED_FACE_CAFE);
        run_op("overlap", 1'b0, 10, 11, 3, '0, -1, 1);
        run_op("from_zero", 1'b0, 0, 500, 2, '0, -1, 2);

        for (int n = 0; n < 12; n++) begin
            bit fl;
            int cnt, src, dst, li, p, ab;
            logic [DATA_W-1:0] pat;
            fl  = bit'($urandom_range(0, 1));
            cnt = $urandom_range(1, 12);
            li  = $urandom_range(1, 3);
            src = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, DEPTH - 1);
            dst = ($urandom_range(0, 3) == 0) ? $urandom_range(DEPTH - 6, DEPTH - 1)
                                              : $urandom_range(0, DEPTH - 1);
            pat = {$urandom, $urandom};
            p   = fl ? (1 + li) : (2 + 2 * li);
            ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, cnt * p - 1) : -1;
            run_op($sformatf("rand%0d", n), fl, src, dst, cnt, pat, ab, li);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/dmem_block_mover.md
Name: dmem_block_mover

Overview:
Initiator-side engine for the 32k x 48-bit data memory port. It copies or fills a block of words by issuing single-word read/write requests and waiting on the memory's done strobe. It sits between the control unit (block/extracode ops, boot loader, test harness) and the data memory, and owns the memory port while busy.

Parameters:
ADDR_W, 15, word address width; address space is 2**ADDR_W words.
DATA_W, 48, memory word width.

Ports:
clk  input  1  clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
i_start  input  1  start request; sampled only in IDLE.
i_fill  input  1  1 = fill dst with i_pattern; 0 = copy src to dst; sampled with i_start.
i_src  input  ADDR_W  source start address (copy only).
i_dst  input  ADDR_W  destination start address.
i_count  input  ADDR_W  word count; 0 = no-op.
i_pattern  input  DATA_W  fill value.
i_abort  input  1  stop at next word boundary.
o_addr  output  ADDR_W  address to memory.
o_read  output  1  memory read request.
o_write  output  1  memory write request.
o_wdata  output  DATA_W  data to memory.
i_rdata  input  DATA_W  data from memory.
i_mdone  input  1  memory completion strobe.
o_busy  output  1  engine owns the memory port.
o_done  output  1  one-cycle completion pulse.
o_aborted  output  1  last operation ended by abort; held until next start.
o_remaining  output  ADDR_W  words still to transfer.

Behaviour:
- Reset: state IDLE. o_addr, o_wdata, o_remaining, o_read, o_write, o_busy, o_done and o_aborted are all 0. Reset mid-transfer takes effect immediately. An in-flight request is abandoned and its i_mdone is ignored.
- States: IDLE, RD, RWAIT, WR, WWAIT.
- o_read = (state==RD). o_write = (state==WR). o_busy = (state!=IDLE).
- Each request is exactly one cycle long.
- IDLE, i_start=1:
  - Latch src, dst, count, fill and pattern. Clear o_aborted.
  - count==0: stay IDLE, o_done=1 next cycle, no memory access.
  - Otherwise: fill -> WR, copy -> RD. o_remaining=count.
- RD: o_addr=src. Next state RWAIT.
- RWAIT: wait for i_mdone. On i_mdone, latch i_rdata into o_wdata and go to WR.
- WR: o_addr=dst, o_wdata = pattern (fill) or latched read data (copy). Next state WWAIT.
- WWAIT: wait for i_mdone. On i_mdone:
  - src+1 and dst+1, modulo 2**ADDR_W (0x7FFF wraps to 0).
  - o_remaining-1.
  - If remaining becomes 0 or abort is pending: go IDLE, o_done=1 for one cycle, o_aborted=1 if the exit was due to abort.
  - Otherwise go to RD (copy) or WR (fill).
- Abort:
  - i_abort is sticky while busy and cleared on entering IDLE. It is ignored in IDLE.
  - The current word always completes. No request is ever withdrawn.
- With a 1-cycle memory and start sampled at edge E0, o_done is high in the cycle after edge E(4N) for copy and E(2N) for fill. Wait states stretch this, since the wait states hold until i_mdone.
- i_start while busy is ignored.
- i_mdone outside RWAIT/WWAIT is ignored.
- Copy is always ascending. Overlap with dst>src replicates the source prefix, and this is defined behaviour.
- Address 0 reads as 0 by memory convention: copying from 0 writes zeros. Writes to 0 are issued normally.
- o_addr and o_wdata hold their last values in IDLE.

Test Plan:
- mem[100..103]=A,B,C,D; copy src=100 dst=200 count=4 -> mem[200..203]=A,B,C,D. 4 reads and 4 writes, alternating. o_done exactly 16 cycles after start edge; o_remaining 4->0.
- Fill dst=0x7FFE count=3 pattern=0x123456789ABC -> writes to 0x7FFE, 0x7FFF, 0x0000. o_done after 6 cycles; no o_read ever asserted.
- count=0 start -> o_done one cycle later, o_busy never 1, no o_read/o_write.
- Copy of 10 words, i_abort pulsed during word 3 read -> word 3 write completes, then IDLE. o_aborted=1, o_remaining=7, exactly 3 destination words modified.
- Memory model delaying i_mdone by 3 cycles, plus reset asserted in the second RWAIT -> next cycle all outputs 0 and state IDLE. Late i_mdone is ignored; a new copy then completes correctly.
- Overlap copy src=10 dst=11 count=3, mem[10]=X -> mem[11..13]=X. Copy from src=0 -> destination zeros.
